// File: rtl/sram_word_ctrl.sv
// 32-bit word load/store bridge onto a 16-bit asynchronous SRAM.
// Each word access is split into two half-word phases, low half first.
module sram_word_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned HALF_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WIDX_W = 17;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_wr_q, is_wr_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_d;
    logic [17:0]         addr_d;
    logic                ce_n_d, oe_n_d, we_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic [31:0]         offset;
    logic [WIDX_W-1:0]   widx_in;

    // Byte address relative to the SRAM window, converted to a word index
    assign offset  = address - 32'(BASE_ADDR);
    assign widx_in = WIDX_W'(offset >> 2);

    // Full half-word transfers only
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // Data bus is driven only from the registered write enable
    assign SRAM_DQ = dq_oe_q ? dq_out_q : 16'hzzzz;

    // Pipeline may advance when idle with no request or at the end of an access
    assign ready = (state_q == DONE) || ((state_q == IDLE) && !rd_en && !wr_en);

    // State, request latch and registered SRAM pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
            widx_q    <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            dq_oe_q   <= 1'b0;
            dq_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            rdata     <= rdata_d;
            SRAM_ADDR <= addr_d;
            SRAM_CE_N <= ce_n_d;
            SRAM_OE_N <= oe_n_d;
            SRAM_WE_N <= we_n_d;
            dq_oe_q   <= dq_oe_d;
            dq_out_q  <= dq_out_d;
        end
    end

    // Next state, phase counting, read capture and next pin values from the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        widx_d   = widx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata;
        addr_d   = SRAM_ADDR;
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        dq_out_d = dq_out_q;

        case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    state_d = LO;
                    cnt_d   = '0;
                    is_wr_d = wr_en;
                    widx_d  = widx_in;
                    wdata_d = wdata;
                end
            end
            LO: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = HI;
                    cnt_d   = '0;
                    if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HI: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // WE_N rises on the last clock of a write phase so addr/data outlast it
        if ((state_d == LO) || (state_d == HI)) begin
            ce_n_d = 1'b0;
            addr_d = {widx_d, (state_d == HI)};
            if (is_wr_d) begin
                dq_oe_d  = 1'b1;
                dq_out_d = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
                we_n_d   = !(cnt_d < LAST_CNT);
            end else begin
                oe_n_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Self-checking bench for sram_word_ctrl with a behavioural async SRAM.
module tb_sram_word_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en, wr_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

    int total = 0;
    int bad   = 0;

    sram_word_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_WE_N (SRAM_WE_N)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: reads whenever selected with OE low, writes on WE_N rising edge
    logic [15:0] mem [0:262143];
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'hzzzz;
    always @(posedge SRAM_WE_N) begin
        if (!SRAM_CE_N) mem[SRAM_ADDR] = SRAM_DQ;
    end

    // Reference: word store indexed by word number, plus the last value loaded
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_rd;

    function automatic int unsigned word_of(input logic [31:0] a);
        return ((a - 32'd1024) / 32'd4) % 32'd131072;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One word access; called just after a rising edge with the controller idle
    task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input bit hold,
                              output int lat, output logic [31:0] rv,
                              output logic [17:0] lo_a, output logic [17:0] hi_a,
                              output int pulses, output int ctrl_err);
        bit   got;
        logic prev_we;
        wr_en = w; rd_en = r; address = a; wdata = d;
        lat = -1; rv = 'x; lo_a = 'x; hi_a = 'x; pulses = 0; ctrl_err = 0;
        got = 0; prev_we = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (!SRAM_CE_N) begin
                if (SRAM_ADDR[0]) hi_a = SRAM_ADDR;
                else              lo_a = SRAM_ADDR;
                if (w ? !SRAM_OE_N : (!SRAM_WE_N || SRAM_OE_N)) ctrl_err++;
            end else if (!SRAM_WE_N || !SRAM_OE_N) begin
                ctrl_err++;
            end
            if (!SRAM_WE_N && prev_we) pulses++;
            prev_we = SRAM_WE_N;
            if (ready) begin
                got = 1; lat = n; rv = rdata;
            end else begin
                @(posedge clk);
            end
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            rd_en = 1'b0; wr_en = 1'b0;
        end
    endtask

    task automatic check_access(input string nm, input logic w, input logic r,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] exp_rd, input bit hold);
        int          lat, pulses, cerr;
        logic [31:0] rv;
        logic [17:0] lo_a, hi_a;
        int unsigned wi;
        wi = word_of(a);
        run_access(w, r, a, d, hold, lat, rv, lo_a, hi_a, pulses, cerr);
        chk({nm, ".lat"},    64'(lat), 64'd5);
        chk({nm, ".rdata"},  64'(rv), 64'(exp_rd));
        chk({nm, ".lo_adr"}, 64'(lo_a), 64'(wi * 2));
        chk({nm, ".hi_adr"}, 64'(hi_a), 64'(wi * 2 + 1));
        chk({nm, ".we_pls"}, 64'(pulses), w ? 64'd2 : 64'd0);
        chk({nm, ".ctrl"},   64'(cerr), 64'd0);
        if (w) ref_mem[wi] = d;
        else   last_rd = exp_rd;
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          found;
        logic [31:0] ra, rd_exp, rdat;
        logic        rw, rr;

        tbl[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b0, 32'd1028, 32'h12345678, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF};
        tbl[4] = '{1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 1'b1, 32'd1032, 32'h0,        32'hA5A55A5A};
        tbl[6] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'h12345678};

        for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
        last_rd = 32'h0;
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
        repeat (2) @(negedge clk);

        chk("rst.ready", 64'(ready), 64'd1);
        chk("rst.rdata", 64'(rdata), 64'd0);
        chk("rst.ctrl",  64'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}), 64'd7);
        chk("rst.addr",  64'(SRAM_ADDR), 64'd0);
        chk("rst.dq_z",  64'(SRAM_DQ === 16'hzzzz), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i])
            check_access($sformatf("tbl%0d", i), tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d,
                         tbl[i].exp_rd, 1'b0);

        chk("mem0", 64'(mem[0]), 64'hBEEF);
        chk("mem1", 64'(mem[1]), 64'hDEAD);
        chk("mem2", 64'(mem[2]), 64'h5678);
        chk("mem3", 64'(mem[3]), 64'h1234);
        chk("mem4", 64'(mem[4]), 64'h5A5A);
        chk("mem5", 64'(mem[5]), 64'hA5A5);

        // Back-to-back reads with the request held across the ready cycle
        check_access("b2b0", 1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b1);
        check_access("b2b1", 1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678, 1'b0);

        // Reset in the HI phase of a write
        wr_en = 1'b1; address = 32'd1424; wdata = 32'hCAFEF00D;
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            @(negedge clk);
            if (!SRAM_CE_N && SRAM_ADDR[0]) found = 1;
        end
        chk("rhi.found", 64'(found), 64'd1);
        chk("rhi.we_lo", 64'(SRAM_WE_N), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rhi.ctrl", 64'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}), 64'd7);
        chk("rhi.dq_z", 64'(SRAM_DQ === 16'hzzzz), 64'd1);
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rhi.ready", 64'(ready), 64'd1);
        chk("rhi.rdata", 64'(rdata), 64'd0);
        last_rd = 32'h0;
        @(posedge clk);
        #1;

        // Random traffic against the word-store reference, including a wrapped address
        for (int i = 0; i < 40; i++) begin
            int unsigned op, slot;
            op   = $urandom_range(0, 2);
            slot = $urandom_range(0, 16);
            ra   = (slot == 16) ? 32'd1020 : 32'd1024 + 32'(slot * 4);
            rw   = (op != 0);
            rr   = (op != 1);
            rdat = $urandom;
            if (rw) rd_exp = last_rd;
            else    rd_exp = ref_mem.exists(word_of(ra)) ? ref_mem[word_of(ra)] : 32'h0;
            check_access($sformatf("rnd%0d", i), rw, rr, ra, rdat, rd_exp, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
